switch_debounce_irq: RTL and testbench
======================================

Name: switch_debounce_irq

Overview:
- Parametrised successor to the plain switch peripheral.
- Synchronises and debounces WIDTH raw switch/button inputs, one counter per bit.
- Latches per-bit rising/falling-edge events into a W1C pending register, with independent rise and fall enables, and raises a level interrupt to the interrupt controller.
- Sits on the CPU peripheral bus with the same zero-wait bus signals as the other I/O peripherals.

Parameters:
- WIDTH, 16: number of switch inputs, legal range 1..32.
- DB_CYCLES, 100000: consecutive cycles a synchronised input must disagree with the debounced value before the debounced value flips; must be >= 1.
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser; must be >= 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- sw  in  WIDTH  raw asynchronous switch inputs.
- addr_i  in  32  byte address; only addr_i[3:2] decoded.
- data_o  out  32  read data, combinational from addr_i[3:2].
- data_i  in  32  write data.
- sel_i  in  2  ignored; every access is full-word.
- rd_i  in  1  read strobe.
- we_i  in  1  write strobe, one write per cycle it is high.
- ack_o  out  1  tied to 1 (zero-wait).
- interrupt  out  1  OR-reduction of the pending register.

Behaviour:
- Reset: rst sampled on the clk edge clears to 0 all of the following: synchroniser flops, debounced value, all counters, pending, RISE_EN and FALL_EN.
  - interrupt = 0 from the cycle after reset is sampled.
  - ack_o = 1 always.
  - data_o is purely combinational and reflects the reset register values.
- Synchroniser: sw passes through SYNC_STAGES flops to give sync[WIDTH-1:0].
- Debounce, per bit i, using counter cnt[i] of width clog2(DB_CYCLES)+1:
  - If sync[i] == stable[i], then cnt[i] <= 0.
  - Else if cnt[i] == DB_CYCLES-1, then stable[i] <= sync[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - Result: stable[i] flips exactly DB_CYCLES cycles after sync[i] first disagrees, provided it disagrees continuously.
  - A glitch shorter than DB_CYCLES cycles never changes stable[i].
  - The counter never wraps.
- Edge detect: rise[i] = stable[i] & ~stable_d[i]; fall[i] = ~stable[i] & stable_d[i].
  - stable_d is stable delayed one cycle; stable_d resets to 0.
- Pending update, per bit, each cycle:
  - set = (rise & RISE_EN) | (fall & FALL_EN).
  - clr = the W1C write mask when a write targets PENDING, else 0.
  - pending <= (pending & ~clr) | set.
  - A set and a clear in the same cycle leaves the bit set (set wins).
- Interrupt: interrupt = |pending, driven from the register. It asserts one cycle after the stable flip.
  - Edge-to-interrupt latency from the sw change is SYNC_STAGES + DB_CYCLES + 1 cycles.
- Register map, addr_i[3:2]; bits >= WIDTH read 0 and ignore writes:
  - 0 VALUE: RO, the debounced stable value. Writes are ignored.
  - 1 PENDING: read returns pending; a write clears each bit where data_i is 1.
  - 2 RISE_EN: RW.
  - 3 FALL_EN: RW.
- Register writes take effect at the clk edge where we_i = 1.
  - Changing an enable does not retro-set or clear pending.
  - An edge in the same cycle as the enable write is judged against the old enable value.
- Reads have no side effects; rd_i is used for nothing beyond documentation.
- Reset mid-operation: all state clears immediately.
  - A switch held high through reset is re-debounced afterwards; stable rises DB_CYCLES cycles after sync goes high.
  - That rise sets no pending bit, because the enables reset to 0.

Test Plan (WIDTH=4, DB_CYCLES=4, SYNC_STAGES=2):
- Reset check: assert rst for 2 cycles, sw=4'hF. Read VALUE=0, PENDING=0, RISE_EN=0, FALL_EN=0, interrupt=0, ack_o=1. After release, VALUE reads 4'hF exactly 2+4 cycles after the first clean edge, and PENDING stays 0.
- Debounce glitch: sw[0] pulses high for 3 cycles then low. VALUE[0] stays 0 and cnt resets. A 4-cycle-or-longer hold sets VALUE[0]=1 at cycle 6 after the sw change.
- Rise interrupt: write RISE_EN=4'h1, then raise sw[0]. PENDING=4'h1 and interrupt=1 at cycle 7 after the sw change. Lowering sw[0] adds no pending bit because FALL_EN=0.
- Fall on a different bit: write FALL_EN=4'h4, then raise and later drop sw[2]. Only the drop sets PENDING[2]; PENDING reads 4'h5 when both events are outstanding.
- W1C: write PENDING=4'h1 with 4'h5 pending. PENDING becomes 4'h4 and interrupt stays 1. Write 4'h4 and interrupt drops the next cycle.
- Simultaneous set and clear: time a write PENDING=4'h1 on the same edge as a new enabled rise of bit 0. PENDING[0] remains 1. Writing 4'h0 to VALUE changes nothing.

Source files
------------

// File: rtl/switch_debounce_irq.sv
// Debounced switch input block with per-bit rise/fall edge capture into a
// write-1-to-clear pending register and a level interrupt to the CPU.
module switch_debounce_irq #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DB_CYCLES   = 100000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [31:0]      addr_i,
    output logic [31:0]      data_o,
    input  logic [31:0]      data_i,
    input  logic [1:0]       sel_i,
    input  logic             rd_i,
    input  logic             we_i,
    output logic             ack_o,
    output logic             interrupt
);

    localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]    r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_wr_pend;
    logic             w_wr_rise;
    logic             w_wr_fall;
    logic             w_unused;

    assign w_sync    = r_sync[SYNC_STAGES-1];
    assign w_wdata   = data_i[WIDTH-1:0];
    assign w_wr_pend = we_i && (addr_i[3:2] == 2'd1);
    assign w_wr_rise = we_i && (addr_i[3:2] == 2'd2);
    assign w_wr_fall = we_i && (addr_i[3:2] == 2'd3);
    assign w_set     = (r_stable & ~r_stable_d & r_rise_en) |
                       (~r_stable & r_stable_d & r_fall_en);
    assign w_clr     = w_wr_pend ? w_wdata : '0;
    assign w_unused  = ^{sel_i, rd_i, addr_i[31:4], addr_i[1:0], data_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= sw;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    // Counter restarts whenever the input agrees again, so glitches never flip stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (w_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= w_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable_d <= '0;
            r_pending  <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
        end else begin
            r_stable_d <= r_stable;
            r_pending  <= (r_pending & ~w_clr) | w_set;
            if (w_wr_rise) r_rise_en <= w_wdata;
            if (w_wr_fall) r_fall_en <= w_wdata;
        end
    end

    always_comb begin
        data_o = '0;
        case (addr_i[3:2])
            2'd0:    data_o[WIDTH-1:0] = r_stable;
            2'd1:    data_o[WIDTH-1:0] = r_pending;
            2'd2:    data_o[WIDTH-1:0] = r_rise_en;
            default: data_o[WIDTH-1:0] = r_fall_en;
        endcase
    end

    assign ack_o     = 1'b1;
    assign interrupt = |r_pending;

endmodule

// File: tb/tb_switch_debounce_irq.sv
// Bench for switch_debounce_irq: directed scenarios plus random traffic,
// all checked every cycle against a sample-history reference model.
module tb_switch_debounce_irq;

    localparam int unsigned W    = 4;
    localparam int unsigned DB   = 4;
    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [W-1:0] sw = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_o;
    logic [31:0] data_i = '0;
    logic [1:0]  sel_i = 2'b11;
    logic        rd_i = 1'b0;
    logic        we_i = 1'b0;
    logic        ack_o;
    logic        interrupt;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    switch_debounce_irq #(.WIDTH(W), .DB_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .sw(sw), .addr_i(addr_i), .data_o(data_o),
        .data_i(data_i), .sel_i(sel_i), .rd_i(rd_i), .we_i(we_i),
        .ack_o(ack_o), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    // Reference model: stable flips once the last DB synchronised samples all differ from it.
    logic [W-1:0] m_swh[$];
    logic [W-1:0] m_synch[$];
    logic [W-1:0] m_stable, m_stable_d, m_pend, m_ren, m_fen;
    logic [W-1:0] n_stable, m_set, m_clr;
    bit           all_diff;

    always @(posedge clk) begin
        if (rst) begin
            m_swh = {};
            m_synch = {};
            for (int k = 0; k < SYNC; k++) m_swh.push_back('0);
            for (int k = 0; k < DB; k++) m_synch.push_back('0);
            m_stable = '0; m_stable_d = '0; m_pend = '0; m_ren = '0; m_fen = '0;
        end else begin
            m_set = ((m_stable & ~m_stable_d) & m_ren) | ((~m_stable & m_stable_d) & m_fen);
            m_clr = (we_i && addr_i[3:2] == 2'd1) ? data_i[W-1:0] : '0;
            n_stable = m_stable;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (m_synch[j][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) n_stable[b] = ~m_stable[b];
            end
            m_pend = (m_pend & ~m_clr) | m_set;
            if (we_i && addr_i[3:2] == 2'd2) m_ren = data_i[W-1:0];
            if (we_i && addr_i[3:2] == 2'd3) m_fen = data_i[W-1:0];
            m_stable_d = m_stable;
            m_stable = n_stable;
            m_swh.push_front(sw);
            void'(m_swh.pop_back());
            m_synch.push_front(m_swh[SYNC-1]);
            void'(m_synch.pop_back());
        end
    end

    function automatic logic [31:0] mread(input logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, m_stable};
            2'd1:    return {28'b0, m_pend};
            2'd2:    return {28'b0, m_ren};
            default: return {28'b0, m_fen};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_data_o", data_o, mread(addr_i[3:2]));
            chk("model_interrupt", {31'b0, interrupt}, {31'b0, |m_pend});
            chk("model_ack", {31'b0, ack_o}, 32'd1);
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr_i = {28'b0, a, 2'b00};
        data_i = d;
        we_i = 1'b1;
        step();
        we_i = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [1:0] a, input logic [31:0] exp);
        addr_i = {28'b0, a, 2'b00};
        #1;
        chk(nm, data_o, exp);
    endtask

    initial begin
        rst = 1'b1;
        sw = 4'hF;
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        lit("rst_value", 2'd0, 32'h0);
        lit("rst_pending", 2'd1, 32'h0);
        lit("rst_rise_en", 2'd2, 32'h0);
        lit("rst_fall_en", 2'd3, 32'h0);
        chk("rst_irq", {31'b0, interrupt}, 32'd0);
        chk("rst_ack", {31'b0, ack_o}, 32'd1);
        step();
        rst = 1'b0;
        step(5);
        lit("post_rst_value_early", 2'd0, 32'h0);
        step();
        lit("post_rst_value_flip", 2'd0, 32'hF);
        lit("post_rst_pending", 2'd1, 32'h0);
        sw = 4'h0;
        step(8);

        sw = 4'h1;
        step(3);
        sw = 4'h0;
        step(8);
        lit("glitch_value", 2'd0, 32'h0);

        sw = 4'h1;
        step(5);
        lit("hold_value_early", 2'd0, 32'h0);
        step();
        lit("hold_value_flip", 2'd0, 32'h1);
        sw = 4'h0;
        step(8);

        wr(2'd2, 32'h1);
        sw = 4'h1;
        step(6);
        lit("rise_pending_early", 2'd1, 32'h0);
        step();
        lit("rise_pending", 2'd1, 32'h1);
        chk("rise_irq", {31'b0, interrupt}, 32'd1);
        sw = 4'h0;
        step(8);
        lit("fall_disabled_pending", 2'd1, 32'h1);

        wr(2'd3, 32'h4);
        sw = 4'h4;
        step(8);
        lit("rise2_no_pending", 2'd1, 32'h1);
        sw = 4'h0;
        step(8);
        lit("fall2_pending", 2'd1, 32'h5);

        wr(2'd1, 32'h1);
        lit("w1c_partial", 2'd1, 32'h4);
        chk("w1c_irq_held", {31'b0, interrupt}, 32'd1);
        wr(2'd1, 32'h4);
        lit("w1c_all", 2'd1, 32'h0);
        chk("w1c_irq_drop", {31'b0, interrupt}, 32'd0);

        sw = 4'h1;
        step(6);
        wr(2'd1, 32'h1);
        lit("set_wins", 2'd1, 32'h1);
        wr(2'd0, 32'h0);
        lit("value_ro", 2'd0, 32'h1);

        sw = 4'hF;
        step(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(5);
        lit("midrst_value_early", 2'd0, 32'h0);
        step();
        lit("midrst_value_flip", 2'd0, 32'hF);
        step(3);
        lit("midrst_pending", 2'd1, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) sw[b] = ~sw[b];
            addr_i = {$urandom_range(0, 15), 4'h0} | {28'b0, 2'($urandom_range(0, 3)), 2'b00};
            data_i = $urandom;
            we_i = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        we_i = 1'b0;
        rst = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
